ground_pixel_writer: RTL and testbench
======================================

# ground_pixel_writer

Depth-tested framebuffer writer that consumes the clipped ground-plane sample stream (x, y, z, palette index, enable) produced by the ground validity stage. It owns the pixel/depth memory port:
- For each valid sample it reads the stored depth and compares it against the sample depth.
- If the sample is nearer, it writes the new colour and depth.
- On request (and after reset) it sweeps the whole buffer to the background value.

## Interface
Parameters:
- WIDTH, 321, pixel columns; legal x range 0..WIDTH-1
- HEIGHT, 321, pixel rows; legal y range 0..HEIGHT-1
- AW, 17, memory address width; must satisfy WIDTH*HEIGHT <= 2^AW
- CLEAR_DEPTH, 511, depth written by clear (farthest)
- CLEAR_COLOR, 0, colour written by clear

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_en  in  1  sample valid (same meaning as upstream en)
- in_ready  out  1  block can accept a sample this cycle
- in_x, in_y, in_z, in_p  in  10 each  signed sample fields (x, y, depth, palette index)
- clear_start  in  1  one-cycle request to clear the buffer
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- mem_addr  out  AW  memory word address, y*WIDTH + x
- mem_re  out  1  read strobe; single-port SRAM returns data one cycle later
- mem_we  out  1  write strobe
- mem_wdata  out  20  {depth[9:0], colour[9:0]}
- mem_rdata  in  20  {depth, colour}, valid the cycle after mem_re

## Operation
- States: CLEAR, IDLE, READ, CMP.
- in_ready = (state==IDLE) && !clear_pend. clear_busy = (state==CLEAR).
- Handshake: a sample is accepted when in_en && in_ready. in_en while in_ready=0 is dropped; there is no backpressure buffering, and upstream stalls on in_ready.
- Accept in IDLE:
  - Sample is rejected if in_p < 0, x or y < 0, x >= WIDTH, or y >= HEIGHT. A rejected sample is consumed, causes no memory access, and the state stays IDLE.
  - Otherwise, latch z and p, register mem_addr = y*WIDTH+x, set mem_re=1, and go to READ.
- READ: mem_re=0, then go to CMP.
- CMP:
  - Signed compare of z_lat against mem_rdata[19:10].
  - If z_lat < stored depth: mem_we=1, mem_wdata={z_lat, p_lat}.
  - Otherwise no write.
  - Always return to IDLE. An equal depth does not overwrite.
- Clear:
  - clear_start in any state sets clear_pend.
  - In IDLE, clear_pend has priority over in_en: go to CLEAR with counter=0 and clear clear_pend.
  - A sample in READ/CMP completes before the clear begins.
  - clear_start while in CLEAR is ignored.
- CLEAR:
  - One write per cycle with mem_addr=counter, mem_we=1, mem_wdata={CLEAR_DEPTH, CLEAR_COLOR}.
  - Counter increments; after address WIDTH*HEIGHT-1 is written, go to IDLE with a clear_done pulse.
- Reset:
  - state=CLEAR, counter=0, clear_pend=0.
  - All registered outputs are 0: mem_addr, mem_re, mem_we, mem_wdata, clear_done.
  - in_ready=0, clear_busy=1.
  - An asserted reset mid-sample or mid-clear abandons the operation immediately.
  - A full clear always follows reset.
- Arithmetic: address multiply uses unsigned x,y (range checked first) truncated to AW bits. Depth compare is 10-bit signed.

## Timing
- All memory-port outputs are registered.
- Accepted valid sample at edge T:
  - mem_re/mem_addr visible T..T+1.
  - mem_rdata sampled at edge T+2.
  - Write (if any) visible T+2..T+3.
  - in_ready returns high after edge T+2, so the next accept is at T+3. Throughput is 1 sample per 3 cycles.
- Rejected sample: in_ready stays high, so back-to-back accepts are possible.
- Clear of N=WIDTH*HEIGHT words:
  - First write visible after the first edge following reset release or following the IDLE->CLEAR edge.
  - The last write is visible for one cycle N edges later.
  - The next edge drops mem_we and raises clear_done for one cycle. clear_done and in_ready rise together.
- mem_re and mem_we are never high in the same cycle.

## Test plan
- WIDTH=4, HEIGHT=3, release reset -> 12 consecutive writes at addr 0..11 with wdata {511,0}, then clear_done for 1 cycle and in_ready=1.
- After clear, accept (x=2,y=1,z=100,p=7) -> mem_re at addr 6, then mem_we at addr 6 with wdata {100,7} two cycles after the accept.
- Same pixel: z=200 with rdata {100,7} -> no write. z=100 -> no write. z=-5 -> write {-5 (10'h3FB), p}.
- Samples with p=-1, x=4, y=-1 -> each accepted with in_ready held high and no mem_re/mem_we.
- clear_start pulsed in the CMP cycle while in_en is held -> the pending write completes, then CLEAR starts with no sample accepted in between, and 12 clear writes follow.
- Assert rst mid-CLEAR at addr 5 -> outputs drop to 0 asynchronously, and after release the clear restarts at addr 0.

Source files
------------

// File: rtl/ground_pixel_writer.sv
// Depth-tested framebuffer writer for the ground-plane sample stream.
// Owns the single-port pixel/depth SRAM: read-compare-write per sample, full-buffer clear on request.
module ground_pixel_writer #(
    parameter int WIDTH       = 321,
    parameter int HEIGHT      = 321,
    parameter int AW          = 17,
    parameter int CLEAR_DEPTH = 511,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_en,
    output logic                in_ready,
    input  logic signed [9:0]   in_x,
    input  logic signed [9:0]   in_y,
    input  logic signed [9:0]   in_z,
    input  logic signed [9:0]   in_p,
    input  logic                clear_start,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [19:0]         mem_wdata,
    input  logic [19:0]         mem_rdata
);
    localparam int N  = WIDTH * HEIGHT;
    // One extra bit so the counter can reach N and mark the sweep as finished.
    localparam int CW = AW + 1;
    localparam logic [19:0] CLEAR_WORD = {10'(CLEAR_DEPTH), 10'(CLEAR_COLOR)};

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ, S_CMP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               clear_pend_q, clear_pend_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic               mem_re_q, mem_re_d;
    logic               mem_we_q, mem_we_d;
    logic [19:0]        mem_wdata_q, mem_wdata_d;
    logic               clear_done_q, clear_done_d;
    logic signed [9:0]  z_lat_q, z_lat_d;
    logic signed [9:0]  p_lat_q, p_lat_d;

    logic [9:0]         x_u, y_u;
    logic               sample_ok;
    logic signed [9:0]  stored_z;
    logic [9:0]         rdata_colour_unused;

    assign x_u                 = in_x;
    assign y_u                 = in_y;
    assign stored_z            = mem_rdata[19:10];
    assign rdata_colour_unused = mem_rdata[9:0];
    // Sign bits are checked first so the unsigned bounds compare only sees non-negative values.
    assign sample_ok = !in_p[9] && !in_x[9] && !in_y[9]
                    && (32'(x_u) < WIDTH) && (32'(y_u) < HEIGHT);

    assign in_ready   = (state_q == S_IDLE) && !clear_pend_q;
    assign clear_busy = (state_q == S_CLEAR);
    assign mem_addr   = mem_addr_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign clear_done = clear_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_pend_d = clear_pend_q | (clear_start && (state_q != S_CLEAR));
        mem_addr_d   = mem_addr_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        clear_done_d = 1'b0;
        z_lat_d      = z_lat_q;
        p_lat_d      = p_lat_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == CW'(N)) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    mem_addr_d  = cnt_q[AW-1:0];
                    mem_we_d    = 1'b1;
                    mem_wdata_d = CLEAR_WORD;
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (clear_pend_q) begin
                    state_d      = S_CLEAR;
                    cnt_d        = '0;
                    clear_pend_d = 1'b0;
                end else if (in_en && sample_ok) begin
                    z_lat_d    = in_z;
                    p_lat_d    = in_p;
                    mem_addr_d = AW'(y_u) * AW'(WIDTH) + AW'(x_u);
                    mem_re_d   = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // Strictly nearer wins; equal depth keeps the existing pixel.
                if (z_lat_q < stored_z) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = {z_lat_q, p_lat_q};
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            clear_pend_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Sample latches are plain data and only meaningful behind the READ/CMP control path.
    always_ff @(posedge clk) begin
        z_lat_q <= z_lat_d;
        p_lat_q <= p_lat_d;
    end

endmodule

// File: tb/tb_ground_pixel_writer.sv
// Scoreboard bench for ground_pixel_writer on a 4x3 buffer with a behavioural single-port SRAM.
module tb_ground_pixel_writer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int CLEAR_WORD = 32'h7FC00;
    localparam int K_RD = 0, K_WR = 1, K_DONE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_en = 1'b0;
    logic              in_ready;
    logic signed [9:0] in_x = '0, in_y = '0, in_z = '0, in_p = '0;
    logic              clear_start = 1'b0;
    logic              clear_busy, clear_done;
    logic [AW-1:0]     mem_addr;
    logic              mem_re, mem_we;
    logic [19:0]       mem_wdata;
    logic [19:0]       mem_rdata = '0;

    ground_pixel_writer #(
        .WIDTH(W), .HEIGHT(H), .AW(AW), .CLEAR_DEPTH(511), .CLEAR_COLOR(0)
    ) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_p(in_p),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [19:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int x, y, z, p;
        bit acc;
        int addr;
        bit wr;
        int wdata;
    } vec_t;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(int kind, int c, int a, int d);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
        sb_q.push_back(e);
    endfunction

    function automatic void pop_check(int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d addr %0h, required none (cycle %0d)",
                     kind, mem_addr, cyc);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind != K_DONE) chk("event_addr", int'(mem_addr), e.addr);
            if (kind == K_WR) chk("event_wdata", int'(mem_wdata), e.data);
        end
    endfunction

    // Monitor: every memory strobe or clear_done pops one expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re && mem_we) chk("re_we_exclusive", 1, 0);
            if (mem_re) pop_check(K_RD);
            if (mem_we) pop_check(K_WR);
            if (clear_done) begin
                pop_check(K_DONE);
                chk("done_ready", int'(in_ready), 1);
                chk("done_busy", int'(clear_busy), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic push_clear(int first_cyc);
        for (int k = 0; k < W * H; k++) push(K_WR, first_cyc + k, k, CLEAR_WORD);
        push(K_DONE, first_cyc + W * H, 0, 0);
    endtask

    task automatic send(input vec_t v);
        wait_ready();
        in_en = 1'b1;
        in_x = 10'(v.x); in_y = 10'(v.y); in_z = 10'(v.z); in_p = 10'(v.p);
        if (v.acc) begin
            push(K_RD, cyc + 1, v.addr, 0);
            if (v.wr) push(K_WR, cyc + 3, v.addr, v.wdata);
        end
        step();
        in_en = 1'b0;
        if (!v.acc) chk("reject_ready", int'(in_ready), 1);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_re"}, int'(mem_re), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_done"}, int'(clear_done), 0);
        chk({tag, "_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(clear_busy), 1);
    endtask

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        // x, y, z, p, accepted, addr, write, wdata
        vecs.push_back('{2, 1, 100, 7, 1, 6, 1, 32'h19007});
        vecs.push_back('{2, 1, 200, 9, 1, 6, 0, 0});
        vecs.push_back('{2, 1, 100, 3, 1, 6, 0, 0});
        vecs.push_back('{2, 1, -5, 4, 1, 6, 1, 32'hFEC04});
        vecs.push_back('{1, 1, 50, -1, 0, 0, 0, 0});
        vecs.push_back('{4, 0, 50, 1, 0, 0, 0, 0});
        vecs.push_back('{0, -1, 50, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 3, 50, 1, 0, 0, 0, 0});
        vecs.push_back('{-1, 0, 50, 1, 0, 0, 0, 0});
        vecs.push_back('{3, 2, 510, 1, 1, 11, 1, 32'h7F801});
        vecs.push_back('{0, 0, -512, 511, 1, 0, 1, 32'h801FF});
        vecs.push_back('{3, 0, 511, 2, 1, 3, 0, 0});

        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        c = cyc;
        push_clear(c + 1);
        repeat (W * H + 1) step();

        foreach (vecs[i]) send(vecs[i]);

        // Clear requested during CMP while upstream keeps in_en asserted.
        wait_ready();
        c = cyc;
        in_en = 1'b1;
        in_x = 10'(1); in_y = 10'(2); in_z = 10'(20); in_p = 10'(5);
        push(K_RD, c + 1, 9, 0);
        push(K_WR, c + 3, 9, 32'h05005);
        push_clear(c + 5);
        step();
        in_x = 10'(0); in_y = 10'(0); in_z = 10'(1); in_p = 10'(1);
        step();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        chk("pend_blocks_ready", int'(in_ready), 0);
        repeat (14) step();
        chk("ready_after_clear", int'(in_ready), 1);
        in_en = 1'b0;

        send('{2, 1, 100, 7, 1, 6, 1, 32'h19007});
        send('{3, 0, -512, 0, 1, 3, 1, 32'h80000});

        // Reset asserted while address 5 of a clear sweep is on the port.
        wait_ready();
        c = cyc;
        clear_start = 1'b1;
        for (int k = 0; k <= 5; k++) push(K_WR, c + 3 + k, k, CLEAR_WORD);
        step();
        clear_start = 1'b0;
        repeat (7) step();
        #5;
        rst = 1'b1;
        #1;
        check_reset_outputs("midclear_reset");
        step();
        step();
        rst = 1'b0;
        c = cyc;
        push_clear(c + 1);
        repeat (W * H + 3) step();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
